// File: rtl/target_reset_sequencer.sv
// Target reset sequencer: one trigger drives N_CHANNELS target reset lines through
// IDLE -> DELAY -> ASSERT -> HOLDOFF -> IDLE, with per-channel compile-time polarity.
// Optional build macro TARGET_RESET_RETRIGGER_EN: a trigger edge during ASSERT extends
// the pulse and widens the channel mask instead of being reported as missed.
module target_reset_sequencer #(
  parameter int unsigned              N_CHANNELS       = 2,
  parameter logic [N_CHANNELS-1:0]    ACTIVE_HIGH_MASK = 'b01,
  parameter int unsigned              CNT_WIDTH        = 16,
  parameter int unsigned              HOLDOFF_CYCLES   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trigger,
  input  logic [N_CHANNELS-1:0] chan_en,
  input  logic [CNT_WIDTH-1:0]  delay_cycles,
  input  logic [CNT_WIDTH-1:0]  pulse_cycles,
  output logic [N_CHANNELS-1:0] target_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  missed
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StDelay   = 2'd1;
  localparam logic [1:0] StAssert  = 2'd2;
  localparam logic [1:0] StHoldoff = 2'd3;

  // Holdoff counter only needs to hold HOLDOFF_CYCLES; keep at least one bit.
  localparam int unsigned HoW = (HOLDOFF_CYCLES < 2) ? 1 : $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [HoW-1:0]       HoLoad = HoW'(HOLDOFF_CYCLES);
  localparam logic [HoW-1:0]       HoOne  = HoW'(1);
  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

  logic [1:0]            state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]  pulse_q, pulse_d;
  logic [N_CHANNELS-1:0] mask_q, mask_d;
  logic [HoW-1:0]        ho_q, ho_d;
  logic                  trig_q;
  logic [N_CHANNELS-1:0] target_reset_q, target_reset_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  missed_q, missed_d;

  logic                  start;
  logic [CNT_WIDTH-1:0]  pulse_eff;

  assign start     = trigger & ~trig_q;
  // A zero pulse length still produces a one-cycle assertion.
  assign pulse_eff = (pulse_cycles == '0) ? CntOne : pulse_cycles;

  // Next-state, counters and registered-output values.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pulse_d  = pulse_q;
    mask_d   = mask_q;
    ho_d     = ho_q;
    done_d   = 1'b0;
    missed_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          mask_d  = chan_en;
          pulse_d = pulse_eff;
          if (delay_cycles == '0) begin
            state_d = StAssert;
            cnt_d   = pulse_eff;
          end else begin
            state_d = StDelay;
            cnt_d   = delay_cycles;
          end
        end
      end

      StDelay: begin
        missed_d = start;
        if (cnt_q == CntOne) begin
          state_d = StAssert;
          cnt_d   = pulse_q;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end

      StAssert: begin
`ifdef TARGET_RESET_RETRIGGER_EN
        if (start) begin
          cnt_d  = pulse_eff;
          mask_d = mask_q | chan_en;
        end else if (cnt_q == CntOne) begin
`else
        missed_d = start;
        if (cnt_q == CntOne) begin
`endif
          if (HOLDOFF_CYCLES == 0) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            state_d = StHoldoff;
            ho_d    = HoLoad;
          end
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end

      StHoldoff: begin
        missed_d = start;
        if (ho_q <= HoOne) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          ho_d = ho_q - HoOne;
        end
      end

      default: state_d = StIdle;
    endcase

    busy_d         = (state_d != StIdle);
    target_reset_d = ~ACTIVE_HIGH_MASK ^ ((state_d == StAssert) ? mask_d : '0);
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      pulse_q        <= '0;
      mask_q         <= '0;
      ho_q           <= '0;
      trig_q         <= 1'b0;
      target_reset_q <= ~ACTIVE_HIGH_MASK;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      missed_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pulse_q        <= pulse_d;
      mask_q         <= mask_d;
      ho_q           <= ho_d;
      trig_q         <= trigger;
      target_reset_q <= target_reset_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      missed_q       <= missed_d;
    end
  end

  assign target_reset = target_reset_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign missed       = missed_q;

endmodule

// File: tb/tb_target_reset_sequencer.sv
// Bench for target_reset_sequencer (N=2, mask 'b01, HOLDOFF 8): directed scenarios checked
// against a per-cycle output history, plus randomized traffic against a timeline model.
module tb_target_reset_sequencer;

  localparam int unsigned HOLD = 8;
  localparam int          HMAX = 8192;
`ifdef TARGET_RESET_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trigger = 1'b0;
  logic [1:0]  chan_en = 2'b00;
  logic [15:0] delay_cycles = 16'd0;
  logic [15:0] pulse_cycles = 16'd0;
  logic [1:0]  target_reset;
  logic        busy, done, missed;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  target_reset_sequencer #(
    .N_CHANNELS      (2),
    .ACTIVE_HIGH_MASK(2'b01),
    .CNT_WIDTH       (16),
    .HOLDOFF_CYCLES  (HOLD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .trigger     (trigger),
    .chan_en     (chan_en),
    .delay_cycles(delay_cycles),
    .pulse_cycles(pulse_cycles),
    .target_reset(target_reset),
    .busy        (busy),
    .done        (done),
    .missed      (missed)
  );

  // Cycle n is the interval after the n-th rising edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0] h_tr   [HMAX];
  logic       h_busy [HMAX];
  logic       h_done [HMAX];
  logic       h_miss [HMAX];
  always @(negedge clk) begin
    if (cyc < HMAX) begin
      h_tr[cyc]   = target_reset;
      h_busy[cyc] = busy;
      h_done[cyc] = done;
      h_miss[cyc] = missed;
    end
  end

  // Inputs for the current cycle, applied just after the rising edge.
  task automatic drive(input logic t, input logic [1:0] en, input int d, input int p,
                       input logic r);
    @(posedge clk);
    #1;
    trigger      = t;
    chan_en      = en;
    delay_cycles = 16'(d);
    pulse_cycles = 16'(p);
    rst          = r;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 2'b00, 0, 0, 1'b0);
  endtask

  task automatic do_reset;
    drive(1'b0, 2'b00, 0, 0, 1'b1);
    drive(1'b0, 2'b00, 0, 0, 1'b1);
  endtask

  // Timeline model: an accepted start at cycle s schedules assertion and done cycles.
  bit         m_valid;
  bit         m_prev;
  int         m_ts, m_as, m_ae, m_td, m_miss_at;
  logic [1:0] m_mask;

  function automatic logic [1:0] exp_tr(input int c);
    logic asserted;
    asserted = m_valid && c >= m_as && c <= m_ae;
    return 2'b10 ^ (asserted ? m_mask : 2'b00);
  endfunction

  function automatic logic exp_busy(input int c);
    return m_valid && c > m_ts && c < m_td;
  endfunction

  function automatic logic exp_done(input int c);
    return m_valid && c == m_td;
  endfunction

  // Applies the inputs seen during cycle n to the model.
  task automatic model_step(input int n, input logic t, input logic [1:0] en, input int d,
                            input int p, input logic r);
    int pe;
    bit st;
    pe = (p == 0) ? 1 : p;
    if (r) begin
      m_valid   = 1'b0;
      m_prev    = 1'b0;
      m_miss_at = -1;
      return;
    end
    st     = t && !m_prev;
    m_prev = t;
    if (!st) return;
    if (!exp_busy(n)) begin
      m_valid = 1'b1;
      m_ts    = n;
      m_as    = n + d + 1;
      m_ae    = m_as + pe - 1;
      m_td    = m_ae + HOLD + 1;
      m_mask  = en;
    end else if (RETRIG && n >= m_as && n <= m_ae) begin
      m_ae   = n + pe;
      m_td   = m_ae + HOLD + 1;
      m_mask = m_mask | en;
    end else begin
      m_miss_at = n + 1;
    end
  endtask

  task automatic test_reset;
    do_reset;
    @(negedge clk);
    n_tests++; if (target_reset !== 2'b10) begin n_fail++; $display("FAIL reset_tr got %b exp 10", target_reset); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
    n_tests++; if (missed !== 1'b0) begin n_fail++; $display("FAIL reset_missed got %b exp 0", missed); end
  endtask

  task automatic test_basic;
    int e;
    do_reset;
    drive(1'b1, 2'b11, 0, 4, 1'b0);
    e = cyc;
    drive(1'b1, 2'b11, 0, 4, 1'b0);
    idle(16);
    n_tests++; if (h_tr[e] !== 2'b10) begin n_fail++; $display("FAIL basic_pre got %b exp 10", h_tr[e]); end
    for (int k = 1; k <= 4; k++) begin
      n_tests++; if (h_tr[e+k] !== 2'b01) begin n_fail++; $display("FAIL basic_tr k=%0d got %b exp 01", k, h_tr[e+k]); end
    end
    n_tests++; if (h_tr[e+5] !== 2'b10) begin n_fail++; $display("FAIL basic_release got %b exp 10", h_tr[e+5]); end
    for (int k = 1; k <= 12; k++) begin
      n_tests++; if (h_busy[e+k] !== 1'b1 || h_done[e+k] !== 1'b0) begin n_fail++; $display("FAIL basic_busy k=%0d got busy=%b done=%b exp 1/0", k, h_busy[e+k], h_done[e+k]); end
    end
    n_tests++; if (h_done[e+13] !== 1'b1 || h_busy[e+13] !== 1'b0) begin n_fail++; $display("FAIL basic_done got done=%b busy=%b exp 1/0", h_done[e+13], h_busy[e+13]); end
    n_tests++; if (h_done[e+14] !== 1'b0) begin n_fail++; $display("FAIL basic_done_width got %b exp 0", h_done[e+14]); end
    for (int k = 0; k <= 14; k++) begin
      n_tests++; if (h_miss[e+k] !== 1'b0) begin n_fail++; $display("FAIL basic_missed k=%0d got %b exp 0", k, h_miss[e+k]); end
    end
  endtask

  task automatic test_delay;
    int e;
    do_reset;
    drive(1'b1, 2'b10, 5, 1, 1'b0);
    e = cyc;
    idle(20);
    for (int k = 1; k <= 5; k++) begin
      n_tests++; if (h_tr[e+k] !== 2'b10 || h_busy[e+k] !== 1'b1) begin n_fail++; $display("FAIL delay_wait k=%0d got tr=%b busy=%b exp 10/1", k, h_tr[e+k], h_busy[e+k]); end
    end
    n_tests++; if (h_tr[e+6] !== 2'b00) begin n_fail++; $display("FAIL delay_assert got %b exp 00", h_tr[e+6]); end
    n_tests++; if (h_tr[e+7] !== 2'b10) begin n_fail++; $display("FAIL delay_release got %b exp 10", h_tr[e+7]); end
    n_tests++; if (h_done[e+15] !== 1'b1 || h_done[e+14] !== 1'b0) begin n_fail++; $display("FAIL delay_done got %b%b exp 01", h_done[e+14], h_done[e+15]); end
  endtask

  task automatic test_pulse_zero;
    int e;
    do_reset;
    drive(1'b1, 2'b11, 0, 0, 1'b0);
    e = cyc;
    idle(14);
    n_tests++; if (h_tr[e+1] !== 2'b01) begin n_fail++; $display("FAIL pz_assert got %b exp 01", h_tr[e+1]); end
    n_tests++; if (h_tr[e+2] !== 2'b10) begin n_fail++; $display("FAIL pz_release got %b exp 10", h_tr[e+2]); end
    n_tests++; if (h_done[e+10] !== 1'b1) begin n_fail++; $display("FAIL pz_done got %b exp 1", h_done[e+10]); end
  endtask

  task automatic test_retrigger;
    int e;
    logic [1:0] exp;
    do_reset;
    drive(1'b1, 2'b01, 0, 4, 1'b0);
    e = cyc;
    drive(1'b0, 2'b00, 0, 4, 1'b0);
    drive(1'b1, 2'b10, 0, 4, 1'b0);
    idle(14);
    for (int k = 1; k <= 7; k++) begin
      if (RETRIG) exp = (k <= 2) ? 2'b11 : (k <= 6) ? 2'b01 : 2'b10;
      else        exp = (k <= 4) ? 2'b11 : 2'b10;
      n_tests++; if (h_tr[e+k] !== exp) begin n_fail++; $display("FAIL retrig_tr k=%0d got %b exp %b", k, h_tr[e+k], exp); end
    end
    for (int k = 1; k <= 8; k++) begin
      n_tests++; if (h_miss[e+k] !== (!RETRIG && k == 3)) begin n_fail++; $display("FAIL retrig_missed k=%0d got %b exp %b", k, h_miss[e+k], (!RETRIG && k == 3)); end
    end
  endtask

  task automatic test_rst_mid;
    int e;
    do_reset;
    drive(1'b1, 2'b11, 0, 4, 1'b0);
    e = cyc;
    drive(1'b0, 2'b11, 0, 4, 1'b0);
    drive(1'b0, 2'b11, 0, 4, 1'b1);
    idle(16);
    n_tests++; if (h_tr[e+2] !== 2'b01) begin n_fail++; $display("FAIL rstmid_before got %b exp 01", h_tr[e+2]); end
    n_tests++; if (h_tr[e+3] !== 2'b10 || h_busy[e+3] !== 1'b0) begin n_fail++; $display("FAIL rstmid_after got tr=%b busy=%b exp 10/0", h_tr[e+3], h_busy[e+3]); end
    for (int k = 3; k <= 17; k++) begin
      n_tests++; if (h_done[e+k] !== 1'b0 || h_busy[e+k] !== 1'b0) begin n_fail++; $display("FAIL rstmid_quiet k=%0d got done=%b busy=%b exp 0/0", k, h_done[e+k], h_busy[e+k]); end
    end
  endtask

  task automatic test_hold_through_reset;
    int r, n_done, n_rise;
    repeat (3) drive(1'b1, 2'b01, 0, 2, 1'b1);
    drive(1'b1, 2'b01, 0, 2, 1'b0);
    r = cyc;
    repeat (25) drive(1'b1, 2'b01, 0, 2, 1'b0);
    n_tests++; if (h_busy[r] !== 1'b0 || h_busy[r+1] !== 1'b1) begin n_fail++; $display("FAIL hold_start got busy %b%b exp 01", h_busy[r], h_busy[r+1]); end
    n_tests++; if (h_done[r+11] !== 1'b1) begin n_fail++; $display("FAIL hold_done got %b exp 1", h_done[r+11]); end
    n_done = 0;
    n_rise = 0;
    for (int k = 0; k < 25; k++) begin
      n_done += int'(h_done[r+k] === 1'b1);
      n_rise += int'(h_busy[r+k] !== 1'b1 && h_busy[r+k+1] === 1'b1);
    end
    n_tests++; if (n_done != 1 || n_rise != 1) begin n_fail++; $display("FAIL hold_once got done=%0d starts=%0d exp 1/1", n_done, n_rise); end
  endtask

  task automatic test_back_to_back;
    int e;
    do_reset;
    drive(1'b1, 2'b01, 0, 2, 1'b0);
    e = cyc;
    repeat (10) drive(1'b0, 2'b01, 0, 2, 1'b0);
    drive(1'b1, 2'b01, 0, 2, 1'b0);
    idle(14);
    n_tests++; if (h_done[e+11] !== 1'b1 || h_busy[e+11] !== 1'b0) begin n_fail++; $display("FAIL b2b_done got done=%b busy=%b exp 1/0", h_done[e+11], h_busy[e+11]); end
    n_tests++; if (h_busy[e+12] !== 1'b1 || h_tr[e+12] !== 2'b11) begin n_fail++; $display("FAIL b2b_restart got busy=%b tr=%b exp 1/11", h_busy[e+12], h_tr[e+12]); end
    n_tests++; if (h_miss[e+12] !== 1'b0) begin n_fail++; $display("FAIL b2b_missed got %b exp 0", h_miss[e+12]); end
    n_tests++; if (h_done[e+22] !== 1'b1) begin n_fail++; $display("FAIL b2b_done2 got %b exp 1", h_done[e+22]); end
  endtask

  task automatic test_random;
    logic       t, r;
    logic [1:0] en;
    int         d, p;
    bit         sync;
    sync = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      t  = ($urandom_range(0, 9) < 3);
      en = 2'($urandom_range(0, 3));
      d  = $urandom_range(0, 6);
      p  = $urandom_range(0, 5);
      r  = (i == 0) || ($urandom_range(0, 199) == 0);
      drive(t, en, d, p, r);
      @(negedge clk);
      if (sync) begin
        n_tests++; if (target_reset !== exp_tr(cyc)) begin n_fail++; $display("FAIL rnd_tr cyc=%0d got %b exp %b", cyc, target_reset, exp_tr(cyc)); end
        n_tests++; if (busy !== exp_busy(cyc)) begin n_fail++; $display("FAIL rnd_busy cyc=%0d got %b exp %b", cyc, busy, exp_busy(cyc)); end
        n_tests++; if (done !== exp_done(cyc)) begin n_fail++; $display("FAIL rnd_done cyc=%0d got %b exp %b", cyc, done, exp_done(cyc)); end
        n_tests++; if (missed !== (cyc == m_miss_at)) begin n_fail++; $display("FAIL rnd_missed cyc=%0d got %b exp %b", cyc, missed, (cyc == m_miss_at)); end
      end
      model_step(cyc, t, en, d, p, r);
      sync = 1'b1;
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_delay;
    test_pulse_zero;
    test_retrigger;
    test_rst_mid;
    test_hold_through_reset;
    test_back_to_back;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
